// File: rtl/hack_mem_responder_if.sv
// hack_mem_responder_if: CPU data bus, keyboard input and screen-update stream of the Hack memory responder.
interface hack_mem_responder_if;
    logic [14:0] addr;
    logic        write_en;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic [15:0] kbd_code;
    logic        scr_valid;
    logic        scr_ready;
    logic [12:0] scr_addr;
    logic [15:0] scr_data;
    logic        scr_overflow;
    modport slave (
        input  addr, write_en, wdata, kbd_code, scr_ready,
        output rdata, scr_valid, scr_addr, scr_data, scr_overflow
    );
    modport master (
        output addr, write_en, wdata, kbd_code, scr_ready,
        input  rdata, scr_valid, scr_addr, scr_data, scr_overflow
    );
endinterface

// File: rtl/hack_mem_responder.sv
// hack_mem_responder: Hack CPU data memory (RAM, screen shadow, keyboard, status)
// with a FIFO that forwards every screen write to a display sink.
module hack_mem_responder #(
    parameter int FIFO_DEPTH = 4
) (
    input logic                  clk,
    input logic                  reset,
    hack_mem_responder_if.slave  bus
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two from 2 to 16");
    end

    logic [15:0] r_ram [0:24575];
    logic [28:0] r_fifo [FIFO_DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [4:0]  r_count;
    logic [15:0] r_kbd;
    logic        r_ovf;

    logic        w_is_ram;
    logic        w_is_scr;
    logic        w_is_kbd;
    logic        w_is_stat;
    logic        w_valid;
    logic        w_pop;
    logic        w_push_req;
    logic        w_push;
    logic        w_drop;
    logic        w_clr;
    logic [28:0] w_head;

    assign w_is_ram   = bus.addr[14:13] != 2'b11;
    assign w_is_scr   = bus.addr[14:13] == 2'b10;
    assign w_is_kbd   = bus.addr == 15'h6000;
    assign w_is_stat  = bus.addr == 15'h6001;

    assign w_valid    = r_count != 5'd0;
    assign w_pop      = w_valid & bus.scr_ready;
    assign w_push_req = bus.write_en & w_is_scr;
    assign w_push     = w_push_req & ((r_count < 5'(FIFO_DEPTH)) | w_pop);
    assign w_drop     = w_push_req & ~w_push;
    assign w_clr      = bus.write_en & w_is_stat & bus.wdata[15];
    assign w_head     = r_fifo[r_rptr];

    // Reads see pre-edge contents, so a same-cycle write is not visible yet.
    assign bus.rdata = w_is_ram  ? r_ram[bus.addr] :
                       w_is_kbd  ? r_kbd :
                       w_is_stat ? {r_ovf, 10'd0, r_count} : 16'd0;

    // Gating with the registered valid keeps the head at zero while empty or in reset.
    assign bus.scr_valid    = w_valid;
    assign bus.scr_addr     = w_valid ? w_head[28:16] : 13'd0;
    assign bus.scr_data     = w_valid ? w_head[15:0] : 16'd0;
    assign bus.scr_overflow = r_ovf;

    always_ff @(posedge clk) begin
        if (bus.write_en && w_is_ram) r_ram[bus.addr] <= bus.wdata;
        if (w_push) r_fifo[r_wptr] <= {bus.addr[12:0], bus.wdata};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_kbd   <= 16'd0;
            r_count <= 5'd0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_kbd   <= bus.kbd_code;
            r_count <= r_count + 5'(w_push) - 5'(w_pop);
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop) r_rptr <= r_rptr + PW'(1);
            r_ovf   <= w_drop | (r_ovf & ~w_clr);
        end
    end
endmodule

// File: doc/hack_mem_responder.md
HACK_MEM_RESPONDER -- requirements
Module: hack_mem_responder

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, is the screen-update FIFO depth; it SHALL be a power of two from 2 to 16.
REQ-002 clk  input  1  rising-edge system clock, the only clock domain.
REQ-003 reset  input  1  asynchronous, active-low reset: 0 = in reset, 1 = run.
REQ-004 addr  input  15  CPU data address (AddrOut).
REQ-005 write_en  input  1  CPU write strobe; a write commits on the rising clk edge.
REQ-006 wdata  input  16  CPU write data (outMem).
REQ-007 rdata  output  16  read data returned to the CPU (inMem).
REQ-008 kbd_code  input  16  raw keyboard scan code, 0 = no key pressed.
REQ-009 scr_valid  output  1  screen-update word available.
REQ-010 scr_ready  input  1  display sink accepts the word.
REQ-011 scr_addr  output  13  screen word offset (addr - 0x4000).
REQ-012 scr_data  output  16  screen word data.
REQ-013 scr_overflow  output  1  sticky flag: a screen update was dropped.

Function
REQ-014 Address map SHALL be:
- 0x0000-0x3FFF: data RAM.
- 0x4000-0x5FFF: screen shadow RAM.
- 0x6000: keyboard register (read-only).
- 0x6001: status register.
- 0x6002-0x7FFF: reads return 0x0000; writes are ignored.
REQ-015 Read path:
- rdata SHALL be purely combinational from addr and the current register/RAM contents, with zero-cycle latency.
- A read of an address being written in the same cycle SHALL return the pre-edge (old) value.
REQ-016 A write to 0x0000-0x5FFF SHALL update the addressed RAM word at the clk edge.
REQ-017 A write to 0x4000-0x5FFF SHALL also push the pair {addr-0x4000, wdata} into the screen FIFO.
REQ-018 The keyboard register SHALL load kbd_code on every clk edge, giving exactly one cycle of latency.
REQ-019 Writes to 0x6000 SHALL be ignored.
REQ-020 Status read value SHALL be: bit15 = scr_overflow; bits[4:0] = FIFO occupancy before the edge; all other bits = 0.
REQ-021 A write to 0x6001 with wdata[15]=1 SHALL clear scr_overflow; all other status bits SHALL be unaffected by writes.
REQ-022 FIFO outputs:
- scr_valid = (occupancy != 0).
- scr_addr/scr_data present the oldest entry.
- Outputs SHALL be registered, with no same-cycle bypass: a push into an empty FIFO makes scr_valid rise on the next cycle.
REQ-023 A pop SHALL occur on any edge where scr_valid=1 and scr_ready=1.
REQ-024 Once scr_valid=1, the head entry SHALL be held stable until it is popped.
REQ-025 A push SHALL be accepted if occupancy < FIFO_DEPTH, or if a pop occurs on the same edge.
- Push and pop on the same edge SHALL leave occupancy unchanged.
REQ-026 Overflow handling:
- A push when full with no pop SHALL drop the entry and set scr_overflow on that edge.
- The shadow RAM write SHALL still occur.
REQ-027 If an overflow event and a status clear occur on the same edge, set SHALL win and scr_overflow SHALL end at 1.
REQ-028 Read and write pointers SHALL wrap modulo FIFO_DEPTH with no lost or duplicated entries.

Reset
REQ-029 While reset=0, the block SHALL asynchronously force the following:
- FIFO empty and pointers 0.
- scr_valid=0, scr_overflow=0.
- keyboard register = 0x0000.
REQ-030 scr_addr and scr_data SHALL read 0 during reset.
REQ-031 RAM contents SHALL NOT be cleared by reset.
REQ-032 Reset asserted mid-transfer SHALL discard all FIFO entries; no pop SHALL be reported after reset release until a new push.
REQ-033 The first edge after reset deasserts SHALL operate normally.

Verification
REQ-034 Write 0x1234 to 0x0010, then read 0x0010 -> rdata=0x1234; a same-cycle read of the written address returns the old value.
REQ-035 kbd_code=0x0041 driven at edge N -> reading 0x6000 returns 0x0000 before edge N and 0x0041 after it.
REQ-036 Write 0xFFFF to 0x4005 with scr_ready=1 -> next cycle scr_valid=1, scr_addr=0x0005, scr_data=0xFFFF; popped on the following edge; reading 0x4005 returns 0xFFFF.
REQ-037 scr_ready=0, five screen writes with FIFO_DEPTH=4:
- status reads 0x8004.
- 5th write dropped; its shadow RAM word is updated.
- Draining yields the first four words in order.
REQ-038 FIFO full with scr_ready=1 and a screen write on the same edge -> write accepted, occupancy stays 4, scr_overflow stays 0.
REQ-039 Write 0x8000 to 0x6001 -> scr_overflow clears.
REQ-040 reset pulsed low with 3 entries queued -> scr_valid=0 immediately, and status reads 0x0000.
